// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - state type, select-width helper and reset values for the TDM scan controller
package tdm_pkg;

  typedef enum logic {
    TDM_IDLE = 1'b0,
    TDM_SCAN = 1'b1
  } tdm_state_e;

  localparam logic        RST_BUSY      = 1'b0;
  localparam logic        RST_SMP_VALID = 1'b0;
  localparam logic        RST_SMP_DATA  = 1'b0;
  localparam logic        RST_DONE      = 1'b0;
  localparam int unsigned RST_SEL       = 0;
  localparam int unsigned RST_SMP_CH    = 0;

  function automatic int sel_width(input int num_ch);
    return (num_ch < 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - modulo-DWELL counter with clear; tc marks the last cycle of a dwell
module dwell_counter #(
  parameter int DWELL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // With DWELL=1 the count stays at 0 and every enabled cycle is terminal.
  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/tdm_scan_ctrl.sv
// rtl/tdm_scan_ctrl.sv - TDM mux scan controller; TDM_SCAN_CONTINUOUS_EN selects free-running frames
module tdm_scan_ctrl
  import tdm_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DWELL  = 3,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mux_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             smp_valid,
  output logic             smp_data,
  output logic [SEL_W-1:0] smp_ch,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  tdm_state_e state;
  logic       tc;
  logic       scan_run;

  // Stop clears the dwell count on the same edge it leaves SCAN.
  assign scan_run = (state == TDM_SCAN) && !stop;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk(clk),
    .rst(rst),
    .en (scan_run),
    .clr(!scan_run),
    .tc (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TDM_IDLE;
      sel       <= SEL_W'(RST_SEL);
      busy      <= RST_BUSY;
      smp_valid <= RST_SMP_VALID;
      smp_data  <= RST_SMP_DATA;
      smp_ch    <= SEL_W'(RST_SMP_CH);
      done      <= RST_DONE;
    end else begin
      smp_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        TDM_IDLE: begin
          if (start && !stop) begin
            state <= TDM_SCAN;
            busy  <= 1'b1;
            sel   <= '0;
          end
        end
        TDM_SCAN: begin
          if (stop) begin
            state <= TDM_IDLE;
            busy  <= 1'b0;
            sel   <= '0;
          end else if (tc) begin
            smp_data  <= mux_in;
            smp_ch    <= sel;
            smp_valid <= 1'b1;
            if (sel == LAST_CH) begin
              done <= 1'b1;
              sel  <= '0;
`ifndef TDM_SCAN_CONTINUOUS_EN
              state <= TDM_IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              sel <= sel + 1'b1;
            end
          end
        end
        default: state <= TDM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// tb/tb_tdm_scan_ctrl.sv - scoreboard bench for tdm_scan_ctrl (4ch/dwell 3 and 3ch/dwell 1)
module tb_tdm_scan_ctrl;

  localparam int NC_A = 4;
  localparam int DW_A = 3;
  localparam int NC_B = 3;
  localparam int DW_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic [3:0] ch_bits = 4'b1010;

  logic [1:0] sel_a, smp_ch_a, sel_b, smp_ch_b;
  logic       busy_a, smp_valid_a, smp_data_a, done_a, mux_a;
  logic       busy_b, smp_valid_b, smp_data_b, done_b, mux_b;

  // Modelled mux: each channel presents one bit of ch_bits.
  assign mux_a = ch_bits[sel_a];
  assign mux_b = ch_bits[sel_b];

  tdm_scan_ctrl #(.NUM_CH(NC_A), .DWELL(DW_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mux_in(mux_a),
    .sel(sel_a), .busy(busy_a), .smp_valid(smp_valid_a), .smp_data(smp_data_a),
    .smp_ch(smp_ch_a), .done(done_a)
  );

  tdm_scan_ctrl #(.NUM_CH(NC_B), .DWELL(DW_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mux_in(mux_b),
    .sel(sel_b), .busy(busy_b), .smp_valid(smp_valid_b), .smp_data(smp_data_b),
    .smp_ch(smp_ch_b), .done(done_b)
  );

  typedef struct {
    int cyc;
    int ch;
    int data;
    int dn;
  } exp_t;

  exp_t q [2][$];
  int   cyc = 0;
  bit   m_act [2];
  int   m_t0 [2];
  int   m_last_ch [2];
  int   m_last_data [2];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic int nc(input int i);
    return (i == 0) ? NC_A : NC_B;
  endfunction

  function automatic int dw(input int i);
    return (i == 0) ? DW_A : DW_B;
  endfunction

  function automatic int exp_sel(input int i);
    return m_act[i] ? ((cyc - m_t0[i]) / dw(i)) % nc(i) : 0;
  endfunction

  // Reference model: a scan started at edge t0 samples channel c at edge t0 + dwell*(c+1).
  always @(posedge clk) begin
    int   k;
    int   ch;
    exp_t e;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        q[i].delete();
        m_last_ch[i] = 0;
        m_last_data[i] = 0;
      end else if (!m_act[i]) begin
        if (start && !stop) begin
          m_act[i] = 1'b1;
          m_t0[i] = cyc;
        end
      end else if (stop) begin
        m_act[i] = 1'b0;
      end else begin
        k = cyc - m_t0[i];
        if (k % dw(i) == 0) begin
          ch = (k / dw(i) - 1) % nc(i);
          e.cyc  = cyc;
          e.ch   = ch;
          e.data = int'(ch_bits[ch]);
          e.dn   = (ch == nc(i) - 1) ? 1 : 0;
          q[i].push_back(e);
          m_last_ch[i] = ch;
          m_last_data[i] = e.data;
`ifndef TDM_SCAN_CONTINUOUS_EN
          if (e.dn != 0) m_act[i] = 1'b0;
`endif
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0d exp=%0d", nm, i, cyc, got, expv);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] sl, sc;
    logic       bz, sv, sd, dn;
    bit         pend;
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) {sl, sc, bz, sv, sd, dn} = {sel_a, smp_ch_a, busy_a, smp_valid_a, smp_data_a, done_a};
      else        {sl, sc, bz, sv, sd, dn} = {sel_b, smp_ch_b, busy_b, smp_valid_b, smp_data_b, done_b};
      chk("busy", i, int'(bz), int'(m_act[i]));
      chk("sel", i, int'(sl), exp_sel(i));
      chk("smp_ch_hold", i, int'(sc), m_last_ch[i]);
      chk("smp_data_hold", i, int'(sd), m_last_data[i]);
      pend = (q[i].size() != 0) && (q[i][0].cyc <= cyc);
      chk("smp_valid", i, int'(sv), int'(pend));
      if (pend) begin
        e = q[i].pop_front();
        if (sv) begin
          chk("smp_ch", i, int'(sc), e.ch);
          chk("smp_data", i, int'(sd), e.data);
          chk("done", i, int'(dn), e.dn);
        end
      end
      if (!sv) chk("done_without_smp", i, int'(dn), 0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    pulse_start();
    repeat (16) @(negedge clk);
    pulse_stop();
    repeat (3) @(negedge clk);

    pulse_start();
    repeat (4) @(negedge clk);
    pulse_stop();
    repeat (4) @(negedge clk);

    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk);

    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (12) @(negedge clk);
    pulse_stop();
    repeat (2) @(negedge clk);

    pulse_start();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    pulse_start();
    repeat (30) @(negedge clk);
    pulse_stop();
    repeat (3) @(negedge clk);

    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      ch_bits = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
